// File: rtl/serial_adder_n_pkg.sv
// serial_adder_n_pkg
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t     : controller states (IDLE, RUN)
//   SUB_CARRY   : carry injected in subtract mode (A + ~B + 1)
//   cnt_width() : step-counter width for a given number of steps, never below 1
package serial_adder_n_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic SUB_CARRY = 1'b1;

    // clog2 gives 0 for a single step; the counter still needs one bit.
    function automatic int cnt_width(input int nstep);
        if (nstep <= 2) begin
            return 1;
        end
        return $clog2(nstep);
    endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if
// Request/result bundle of the digit-serial adder/subtractor.
//   start      : request, accepted at any rising edge where busy is low
//   A, B       : operands, captured together with start
//   ci, sub    : carry-in (add only) and subtract select
//   busy       : operation in flight; start is ignored while high
//   done       : one-cycle pulse, s/co/ovf valid from this cycle on
//   s, co, ovf : result, carry out of MSB, two's-complement overflow
//
// Handshake: start acts as "valid" and !busy as "ready"; a transfer happens
// on a rising edge where start=1 and busy=0. There is no back-pressure on the
// result side: done pulses once and s/co/ovf are held until the next done.
interface serial_adder_n_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ci;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, A, B, ci, sub,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, A, B, ci, sub,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/serial_adder_n_fa_digit.sv
// fa_digit
// DIGIT-bit ripple of full-adder cells.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   sum   : digit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (overflow detection)
module fa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // A procedural carry variable keeps the ripple free of combinational
    // self-loops on a vector net.
    always_comb begin
        logic cv;
        cv    = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb  = cv;
            sum[i] = a[i] ^ b[i] ^ cv;
            cv     = (a[i] & b[i]) | (cv & (a[i] ^ b[i]));
        end
        cout = cv;
    end

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n
// Digit-serial adder/subtractor: processes one DIGIT-bit slice of two
// WIDTH-bit operands per clock, least significant slice first, with the
// carry held in a register between slices.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : request/result bundle (slave side)
//   dbg_state : current controller state
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_n_if.slave bus,
    output state_t          dbg_state
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = cnt_width(NSTEP);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_step;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;

    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;

    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             done_q;

    // Operands shift right every step, so the active digit is always the
    // low slice.
    fa_digit #(
        .DIGIT (DIGIT)
    ) u_fa (
        .a     (op_a[DIGIT-1:0]),
        .b     (op_b[DIGIT-1:0]),
        .cin   (carry),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // Result shift register fills from the top; after NSTEP steps the first
    // digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_next = d_sum;
        end else begin : g_shift
            assign res_next = {d_sum, res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last_step  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            res    <= '0;
            s_q    <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Subtract is A + ~B + 1: invert B here, inject the 1 as carry.
                op_a  <= bus.A;
                op_b  <= bus.sub ? ~bus.B : bus.B;
                carry <= bus.sub ? SUB_CARRY : bus.ci;
                cnt   <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                carry <= d_cout;
                res   <= res_next;
                cnt   <= cnt + CW'(1);
                if (last_step) begin
                    s_q    <= res_next;
                    co_q   <= d_cout;
                    ovf_q  <= d_cout ^ d_cmsb;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.co    = co_q;
    assign bus.ovf   = ovf_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;
    import serial_adder_n_pkg::*;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NSTEP = WIDTH / DIGIT;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] last_s;

    serial_adder_n_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_n #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model: plain integer arithmetic. Returns {ovf, co, s}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sb);
        logic [WIDTH-1:0] bop;
        logic [WIDTH:0]   sum;
        logic             ov;
        bop = sb ? ~b : b;
        sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, (sb ? 1'b1 : cin)};
        // Same-sign operands giving a different-sign result.
        ov  = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        return {ov, sum[WIDTH], sum[WIDTH-1:0]};
    endfunction

    // Driver: called about 1 time unit after a rising edge.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sb, input bit hold, input bit chain);
        logic [WIDTH+1:0] exp_v;
        int lat;
        exp_v     = model(a, b, cin, sb);
        bus.A     = a;
        bus.B     = b;
        bus.ci    = cin;
        bus.sub   = sb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("busy_rise", 32'(bus.busy), 32'd1);
        if (!hold) bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= NSTEP + 4; k++) begin
            // Operands change after capture; result must not follow them.
            bus.A   = WIDTH'($urandom);
            bus.B   = WIDTH'($urandom);
            bus.ci  = 1'($urandom);
            bus.sub = 1'($urandom);
            @(posedge clk); #1;
            if (hold && k >= NSTEP - 1) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            check("s_stable_run", 32'(bus.s), 32'(last_s));
        end
        check("latency", 32'(lat), 32'(NSTEP));
        check("s", 32'(bus.s), 32'(exp_v[WIDTH-1:0]));
        check("co", 32'(bus.co), 32'(exp_v[WIDTH]));
        check("ovf", 32'(bus.ovf), 32'(exp_v[WIDTH+1]));
        check("busy_fall", 32'(bus.busy), 32'd0);
        last_s = exp_v[WIDTH-1:0];
        if (!chain) begin
            @(posedge clk); #1;
            check("done_pulse", 32'(bus.done), 32'd0);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        bit got_done;
        bit hold;
        bit chain;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.ci    = 1'b0;
        bus.sub   = 1'b0;
        last_s    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_co", 32'(bus.co), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);

        // start held through RUN with changing operands
        do_op(16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: second start issued in the done cycle
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(16'h1000, 16'h2000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the second RUN cycle
        bus.A     = 16'h1357;
        bus.B     = 16'h2468;
        bus.ci    = 1'b0;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_s", 32'(bus.s), 32'd0);
        check("mid_rst_co", 32'(bus.co), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        rst    = 1'b0;
        last_s = '0;
        got_done = 1'b0;
        for (int k = 0; k < NSTEP + 2; k++) begin
            @(posedge clk); #1;
            if (bus.done) got_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(got_done), 32'd0);
        do_op(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            hold  = 1'($urandom_range(0, 1));
            chain = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            do_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), hold, chain);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
